sar_search: RTL

//  Successive-approximation controller: the driving end of a 4-bit magnitude comparator.
//  It presents trial codes on 'trial' and consumes less/equal/greater (trial vs. unknown target).

---
 rtl/sar_search_pkg.sv | 42 ++++
 rtl/sar_search_if.sv | 33 +++
 rtl/sar_search.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// ============================================================================
// Module  : sar_search_pkg
// Purpose : State encodings and comparator-flag resolution for sar_search.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sar_search_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TEST = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        DEC_LESS    = 2'd0,
        DEC_GREATER = 2'd1,
        DEC_EQUAL   = 2'd2
    } dec_t;

    // Flag vector is {equal, greater, less}, ordered from highest to lowest priority
    localparam logic [2:0] FLAG_EQUAL   = 3'b100;
    localparam logic [2:0] FLAG_GREATER = 3'b010;

    function automatic dec_t resolve_flags(input logic [2:0] flags);
        if ((flags & FLAG_EQUAL) != 3'b000) begin
            return DEC_EQUAL;
        end
        if ((flags & FLAG_GREATER) != 3'b000) begin
            return DEC_GREATER;
        end
        return DEC_LESS;
    endfunction

    function automatic logic flags_illegal(input logic [2:0] flags);
        return (flags == 3'b000) || ((flags & (flags - 3'd1)) != 3'b000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search_if.sv
// ============================================================================
// Module  : sar_search_if
// Purpose : Comparator feedback, start request and search-result bundle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             less;
    logic             equal;
    logic             greater;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             prot_err;

    modport master (
        input  start, less, equal, greater,
        output trial, busy, done, result, found, prot_err
    );

    modport slave (
        output start, less, equal, greater,
        input  trial, busy, done, result, found, prot_err
    );
endinterface

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// Module  : sar_search
// Purpose : MSB-first successive-approximation search driving a magnitude
//           comparator; all outputs registered.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sar_search_if.master   bus
);

    localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  w_acc_nxt;

    logic [WIDTH-1:0]  r_trial;
    logic [WIDTH-1:0]  w_trial_nxt;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  w_result_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_found;
    logic              w_found_nxt;
    logic              r_prot_err;
    logic              w_prot_err_nxt;

    logic [2:0]        w_flags;
    dec_t              w_dec;
    logic              w_bad_flags;
    logic              w_last;
    logic [WIDTH-1:0]  w_bit_cur;
    logic [WIDTH-1:0]  w_bit_dn;

    assign w_flags     = {bus.equal, bus.greater, bus.less};
    assign w_dec       = resolve_flags(w_flags);
    assign w_bad_flags = flags_illegal(w_flags);
    assign w_last      = (w_dec == DEC_EQUAL) || (r_idx == '0);
    assign w_bit_cur   = WIDTH'(1) << r_idx;
    // Only consumed while idx > 0, so the wrap at idx == 0 never reaches a register
    assign w_bit_dn    = WIDTH'(1) << (r_idx - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_acc      <= '0;
            r_trial    <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_trial    <= w_trial_nxt;
            r_result   <= w_result_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_found    <= w_found_nxt;
            r_prot_err <= w_prot_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_TEST;
            ST_TEST: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Computes the next value of every registered output and of idx/acc
    always_comb begin
        w_idx_nxt      = r_idx;
        w_acc_nxt      = r_acc;
        w_trial_nxt    = r_trial;
        w_result_nxt   = r_result;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_found_nxt    = r_found;
        w_prot_err_nxt = r_prot_err;
        case (r_state)
            ST_IDLE: begin
                w_trial_nxt = r_result;
                if (bus.start) begin
                    w_idx_nxt      = IDX_MSB;
                    w_acc_nxt      = '0;
                    w_found_nxt    = 1'b0;
                    w_prot_err_nxt = 1'b0;
                    w_trial_nxt    = MSB_BIT;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_TEST: begin
                w_prot_err_nxt = r_prot_err | w_bad_flags;
                case (w_dec)
                    DEC_EQUAL: begin
                        w_acc_nxt   = r_trial;
                        w_found_nxt = 1'b1;
                    end
                    DEC_GREATER: w_acc_nxt = r_acc;
                    default:     w_acc_nxt = r_acc | w_bit_cur;
                endcase
                if (w_last) begin
                    w_result_nxt = w_acc_nxt;
                    w_trial_nxt  = w_acc_nxt;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx - 1'b1;
                    w_trial_nxt = w_acc_nxt | w_bit_dn;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_trial_nxt = r_result;
            end
            default: begin
                w_trial_nxt = r_result;
            end
        endcase
    end

    assign bus.trial    = r_trial;
    assign bus.result   = r_result;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.found    = r_found;
    assign bus.prot_err = r_prot_err;

endmodule

`default_nettype wire
